// File: rtl/sigma_delta_mod.sv
// sigma_delta_mod: second-order 1-bit sigma-delta modulator, ZOH-interpolated PCM input.
// Define SDM_DITHER_EN to add +/-1 LSB LFSR dither to the second integrator.
module sigma_delta_mod #(
  parameter int IN_WIDTH  = 24,
  parameter int ACC_WIDTH = 32,
  parameter int OSR       = 64
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [IN_WIDTH-1:0] pcm_in,
  input  logic                pcm_valid,
  output logic                pcm_ready,
  input  logic                bit_en,
  output logic                bit_out,
  output logic                bit_valid,
  output logic                underrun
);

  localparam int CW = (OSR > 1) ? $clog2(OSR) : 1;
  localparam int SW = ACC_WIDTH + 2;

  localparam logic signed [SW-1:0] FS =
    {{(SW-IN_WIDTH){1'b0}}, 1'b1, {(IN_WIDTH-1){1'b0}}};
  localparam logic signed [SW-1:0] AMAX =
    {3'b000, {(ACC_WIDTH-1){1'b1}}};
  localparam logic signed [SW-1:0] AMIN =
    {3'b111, {(ACC_WIDTH-1){1'b0}}};

  typedef enum logic {IDLE, RUN} state_e;

  state_e state_q, state_d;

  logic [IN_WIDTH-1:0] cur_q, cur_d;
  logic [IN_WIDTH-1:0] nxt_q, nxt_d;
  logic                nxt_full_q, nxt_full_d;
  logic [CW-1:0]       cnt_q, cnt_d;

  logic signed [ACC_WIDTH-1:0] i1_q, i1_d;
  logic signed [ACC_WIDTH-1:0] i2_q, i2_d;

  logic bit_q, bit_d;
  logic bval_q, bval_d;
  logic unr_q, unr_d;

  logic push, tick, wrap, load, take;

  logic signed [SW-1:0] fb, x, s1, s2, dith;
  logic signed [ACC_WIDTH-1:0] e1, i2n;

  function automatic logic signed [ACC_WIDTH-1:0] sat(
    input logic signed [SW-1:0] v
  );
    if (v > AMAX)      sat = AMAX[ACC_WIDTH-1:0];
    else if (v < AMIN) sat = AMIN[ACC_WIDTH-1:0];
    else               sat = v[ACC_WIDTH-1:0];
  endfunction

  assign push = pcm_valid && pcm_ready;
  assign tick = (state_q == RUN) && bit_en;
  assign wrap = tick && (cnt_q == CW'(OSR - 1));
  assign load = (state_q == IDLE) && nxt_full_q;
  assign take = load || (wrap && nxt_full_q);

`ifdef SDM_DITHER_EN
  logic [15:0] lfsr_q, lfsr_d;

  always_comb begin
    lfsr_d = lfsr_q;
    if (tick)
      lfsr_d = {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5],
                lfsr_q[15:1]};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) lfsr_q <= 16'hACE1;
    else        lfsr_q <= lfsr_d;
  end

  assign dith = lfsr_q[0] ? {{(SW-1){1'b0}}, 1'b1} : {SW{1'b1}};
`else
  assign dith = '0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cur_q      <= '0;
      nxt_q      <= '0;
      nxt_full_q <= 1'b0;
      cnt_q      <= '0;
      i1_q       <= '0;
      i2_q       <= '0;
      bit_q      <= 1'b0;
      bval_q     <= 1'b0;
      unr_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cur_q      <= cur_d;
      nxt_q      <= nxt_d;
      nxt_full_q <= nxt_full_d;
      cnt_q      <= cnt_d;
      i1_q       <= i1_d;
      i2_q       <= i2_d;
      bit_q      <= bit_d;
      bval_q     <= bval_d;
      unr_q      <= unr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (nxt_full_q) state_d = RUN;
      RUN:  state_d = RUN;
    endcase
  end

  // Sums carry two guard bits so saturation sees the true value.
  always_comb begin
    fb  = bit_q ? FS : -FS;
    x   = {{(SW-IN_WIDTH){cur_q[IN_WIDTH-1]}}, cur_q};
    s1  = {{2{i1_q[ACC_WIDTH-1]}}, i1_q} + x - fb;
    e1  = sat(s1);
    s2  = {{2{i2_q[ACC_WIDTH-1]}}, i2_q}
        + {{2{e1[ACC_WIDTH-1]}}, e1} - fb + dith;
    i2n = sat(s2);
  end

  always_comb begin
    cur_d      = cur_q;
    cnt_d      = cnt_q;
    i1_d       = i1_q;
    i2_d       = i2_q;
    bit_d      = bit_q;
    bval_d     = 1'b0;
    unr_d      = 1'b0;
    nxt_d      = push ? pcm_in : nxt_q;
    nxt_full_d = push || (nxt_full_q && !take);
    if (load) begin
      cur_d = nxt_q;
      cnt_d = '0;
    end
    if (tick) begin
      i1_d   = e1;
      i2_d   = i2n;
      bit_d  = ~i2n[ACC_WIDTH-1];
      bval_d = 1'b1;
      cnt_d  = wrap ? '0 : cnt_q + 1'b1;
      if (wrap) begin
        if (nxt_full_q) cur_d = nxt_q;
        else            unr_d = 1'b1;
      end
    end
  end

  assign pcm_ready = ~nxt_full_q;
  assign bit_out   = bit_q;
  assign bit_valid = bval_q;
  assign underrun  = unr_q;

endmodule
